// File: rtl/text_serializer_if.sv
// Text-RAM read port plus serial transmit status for text_serializer.
// master = RAM side / testbench driver, slave = the serializer itself.
interface text_serializer_if;
    logic        read_enable;
    logic [7:0]  read_address;
    logic [23:0] ram_q;
    logic        tx;
    logic        busy;
    logic        word_done;
    logic [7:0]  last_address;
    logic [7:0]  overrun_count;

    modport master (
        output read_enable, read_address, ram_q,
        input  tx, busy, word_done, last_address, overrun_count
    );

    modport slave (
        input  read_enable, read_address, ram_q,
        output tx, busy, word_done, last_address, overrun_count
    );
endinterface

// File: rtl/text_serializer.sv
// Serializes 24-bit text-RAM words as three UART byte frames, MSB byte first,
// with a one-entry pending slot. Optional even parity: TEXT_SERIALIZER_PARITY_EN.
module text_serializer #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic               clk,
    input  logic               reset,
    text_serializer_if.slave   bus
);

`ifdef TEXT_SERIALIZER_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4
    } state_t;
`endif

    localparam logic [7:0] CNT_LAST_C = 8'(CLKS_PER_BIT - 1);

    function automatic logic [7:0] sel_byte(input logic [23:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[23:16];
            2'd1:    b = word[15:8];
            2'd2:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef TEXT_SERIALIZER_PARITY_EN
    function automatic logic parity_even(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [2:0]  bit_r, bit_s;
    logic [1:0]  byte_r, byte_s;
    logic [23:0] word_r, word_s;
    logic [7:0]  addr_r, addr_s;
    logic        pend_v_r, pend_v_s;
    logic [23:0] pend_word_r, pend_word_s;
    logic [7:0]  pend_addr_r, pend_addr_s;
    logic        fetch_v_r;
    logic [7:0]  fetch_addr_r;
    logic        tx_r, tx_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic [7:0]  last_r, last_s;
    logic [7:0]  ovr_r, ovr_s;
    logic        bit_end_s;
    logic [7:0]  cur_byte_s;

    // Fetch stage: remember the address so it pairs with ram_q one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_v_r    <= 1'b0;
            fetch_addr_r <= 8'h00;
        end else begin
            fetch_v_r <= bus.read_enable;
            if (bus.read_enable) begin
                fetch_addr_r <= bus.read_address;
            end else begin
                fetch_addr_r <= fetch_addr_r;
            end
        end
    end

    // Next-state for shifter, pending slot and counters; outputs derive from next state.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_s       = bit_r;
        byte_s      = byte_r;
        word_s      = word_r;
        addr_s      = addr_r;
        pend_v_s    = pend_v_r;
        pend_word_s = pend_word_r;
        pend_addr_s = pend_addr_r;
        last_s      = last_r;
        ovr_s       = ovr_r;
        done_s      = 1'b0;
        bit_end_s   = (cnt_r == CNT_LAST_C);

        if (state_r == S_IDLE) begin
            cnt_s = 8'h00;
        end else if (bit_end_s) begin
            cnt_s = 8'h00;
        end else begin
            cnt_s = cnt_r + 8'h01;
        end

        case (state_r)
            S_IDLE: begin
                state_s = S_IDLE;
            end
            S_START: begin
                if (bit_end_s) begin
                    state_s = S_DATA;
                    bit_s   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    if (bit_r == 3'd7) begin
`ifdef TEXT_SERIALIZER_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end
            end
`ifdef TEXT_SERIALIZER_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    state_s = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    if (byte_r != 2'd2) begin
                        byte_s  = byte_r + 2'd1;
                        state_s = S_START;
                    end else begin
                        done_s  = 1'b1;
                        last_s  = addr_r;
                        byte_s  = 2'd0;
                        state_s = S_IDLE;
                        // Chain the pending word onto this very edge.
                        if (pend_v_r) begin
                            state_s  = S_START;
                            word_s   = pend_word_r;
                            addr_s   = pend_addr_r;
                            pend_v_s = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // A fetched word lands after the shifter/pending decisions above, so a
        // slot freed at this edge is already visible to it.
        if (fetch_v_r) begin
            if (state_s == S_IDLE) begin
                state_s = S_START;
                word_s  = bus.ram_q;
                addr_s  = fetch_addr_r;
                cnt_s   = 8'h00;
                byte_s  = 2'd0;
                bit_s   = 3'd0;
            end else if (!pend_v_s) begin
                pend_v_s    = 1'b1;
                pend_word_s = bus.ram_q;
                pend_addr_s = fetch_addr_r;
            end else if (ovr_r != 8'hFF) begin
                ovr_s = ovr_r + 8'h01;
            end else begin
                ovr_s = ovr_r;
            end
        end

        cur_byte_s = sel_byte(word_s, byte_s);
        case (state_s)
            S_START:  tx_s = 1'b0;
            S_DATA:   tx_s = cur_byte_s[bit_s];
`ifdef TEXT_SERIALIZER_PARITY_EN
            S_PARITY: tx_s = parity_even(cur_byte_s);
`endif
            default:  tx_s = 1'b1;
        endcase
        busy_s = (state_s != S_IDLE) | pend_v_s;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= 8'h00;
            bit_r       <= 3'd0;
            byte_r      <= 2'd0;
            word_r      <= 24'h000000;
            addr_r      <= 8'h00;
            pend_v_r    <= 1'b0;
            pend_word_r <= 24'h000000;
            pend_addr_r <= 8'h00;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            last_r      <= 8'h00;
            ovr_r       <= 8'h00;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_r       <= bit_s;
            byte_r      <= byte_s;
            word_r      <= word_s;
            addr_r      <= addr_s;
            pend_v_r    <= pend_v_s;
            pend_word_r <= pend_word_s;
            pend_addr_r <= pend_addr_s;
            tx_r        <= tx_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            last_r      <= last_s;
            ovr_r       <= ovr_s;
        end
    end

    assign bus.tx            = tx_r;
    assign bus.busy          = busy_r;
    assign bus.word_done     = done_r;
    assign bus.last_address  = last_r;
    assign bus.overrun_count = ovr_r;

endmodule

// File: tb/tb_text_serializer.sv
// Self-checking bench for text_serializer: a time-based schedule model predicts
// every cycle of tx/busy/word_done/last_address/overrun_count.
module tb_text_serializer;

    localparam int CPB = 2;
`ifdef TEXT_SERIALIZER_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int W = 3 * F * CPB;

    logic clk;
    logic reset;
    text_serializer_if bus ();

    text_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int drops  = 0;

    // Accepted words: delivery edge, first tx edge, end edge, address, data.
    int          w_dl[$];
    int          w_st[$];
    int          w_en[$];
    logic [7:0]  w_ad[$];
    logic [23:0] w_wd[$];

    logic        f_v;
    logic [7:0]  f_addr;
    logic [23:0] f_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        w_dl.delete(); w_st.delete(); w_en.delete(); w_ad.delete(); w_wd.delete();
        drops = 0;
        f_v   = 1'b0;
    endtask

    // A word is accepted if fewer than two words are still unfinished at its
    // delivery edge; it starts immediately or right after the last scheduled one.
    task automatic model_deliver(input int d, input logic [7:0] a, input logic [23:0] wd);
        int n = 0;
        int sched_end = 0;
        int st;
        foreach (w_en[i]) begin
            if (w_en[i] > d) n++;
            if (w_en[i] > sched_end) sched_end = w_en[i];
        end
        if (n >= 2) begin
            drops++;
        end else begin
            st = (n == 0) ? d : sched_end;
            w_dl.push_back(d); w_st.push_back(st); w_en.push_back(st + W);
            w_ad.push_back(a); w_wd.push_back(wd);
        end
    endtask

    function automatic logic exp_tx(input int c);
        foreach (w_st[i]) begin
            if (w_st[i] <= c && c < w_en[i]) begin
                int o  = c - w_st[i];
                int bi = o / (F * CPB);
                int bp = (o % (F * CPB)) / CPB;
                logic [23:0] sh = w_wd[i] >> (8 * (2 - bi));
                logic [7:0]  b  = sh[7:0];
                if (bp == 0) return 1'b0;
                if (bp <= 8) return b[bp - 1];
                if (F == 11 && bp == 9) return ^b;
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int c);
        foreach (w_dl[i]) if (w_dl[i] <= c && c < w_en[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_done(input int c);
        foreach (w_en[i]) if (w_en[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_last(input int c);
        int best = -1;
        logic [7:0] la = 8'h00;
        foreach (w_en[i]) begin
            if (w_en[i] <= c && w_en[i] > best) begin
                best = w_en[i];
                la   = w_ad[i];
            end
        end
        return la;
    endfunction

    task automatic check_cycle();
        chk("tx",            32'(bus.tx),            32'(exp_tx(cyc)));
        chk("busy",          32'(bus.busy),          32'(exp_busy(cyc)));
        chk("word_done",     32'(bus.word_done),     32'(exp_done(cyc)));
        chk("last_address",  32'(bus.last_address),  32'(exp_last(cyc)));
        chk("overrun_count", 32'(bus.overrun_count), 32'((drops > 255) ? 255 : drops));
    endtask

    // One clock: present a request, let the RAM answer one cycle later, check outputs.
    task automatic tick(input logic re, input logic [7:0] addr, input logic [23:0] wd);
        bus.read_enable  = re;
        bus.read_address = addr;
        @(posedge clk);
        cyc++;
        #1;
        if (f_v) model_deliver(cyc, f_addr, f_word);
        f_v    = re & reset;
        f_addr = addr;
        f_word = wd;
        bus.ram_q       = re ? wd : 24'($urandom);
        bus.read_enable = 1'b0;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 24'h000000);
    endtask

    int d0;

    initial begin
        reset            = 1'b0;
        bus.read_enable  = 1'b0;
        bus.read_address = 8'h00;
        bus.ram_q        = 24'h000000;
        model_reset();

        // Reset values.
        idle(3);
        chk("rst_tx",   32'(bus.tx),            32'd1);
        chk("rst_busy", 32'(bus.busy),          32'd0);
        chk("rst_ovr",  32'(bus.overrun_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single word.
        tick(1'b1, 8'h05, 24'h414243);
        idle(W + 10);
        chk("single_last", 32'(bus.last_address), 32'h05);
        chk("single_busy", 32'(bus.busy),         32'd0);

        // Back-to-back pulses.
        tick(1'b1, 8'h06, 24'h000001);
        tick(1'b1, 8'h07, 24'h000002);
        idle(2 * W + 10);
        chk("b2b_ovr", 32'(bus.overrun_count), 32'd0);

        // Fetch lands on the last-stop edge with pending full.
        tick(1'b1, 8'h10, 24'hA5A5A5);
        d0 = cyc + 1;
        tick(1'b1, 8'h11, 24'h5A5A5A);
        while (cyc < d0 + W - 2) tick(1'b0, 8'h00, 24'h000000);
        tick(1'b1, 8'h12, 24'hC3C3C3);
        idle(3 * W + 10);
        chk("simul_ovr",  32'(bus.overrun_count), 32'd0);
        chk("simul_last", 32'(bus.last_address),  32'h12);

        // Three requests inside one word time.
        tick(1'b1, 8'h20, 24'h111111);
        idle(5);
        tick(1'b1, 8'h21, 24'h222222);
        idle(5);
        tick(1'b1, 8'h22, 24'h333333);
        idle(2 * W + 10);
        chk("overrun_one", 32'(bus.overrun_count), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0)
                tick(1'b1, 8'($urandom), 24'($urandom));
            else
                tick(1'b0, 8'($urandom), 24'($urandom));
        end
        idle(2 * W + 10);

        // Saturation after 300+ drops.
        for (int i = 0; i < 330; i++) tick(1'b1, 8'($urandom), 24'($urandom));
        idle(2 * W + 10);
        chk("overrun_sat", 32'(bus.overrun_count), 32'd255);

        // Reset during byte 1 DATA.
        tick(1'b1, 8'h33, 24'h55AA0F);
        idle(F * CPB + 4 * CPB);
        reset = 1'b0;
        #1;
        chk("midrst_tx",   32'(bus.tx),        32'd1);
        chk("midrst_busy", 32'(bus.busy),      32'd0);
        chk("midrst_done", 32'(bus.word_done), 32'd0);
        model_reset();
        idle(3);
        @(negedge clk);
        reset = 1'b1;
        idle(W);
        tick(1'b1, 8'h44, 24'h070100);
        idle(W + 10);
        chk("post_rst_last", 32'(bus.last_address),  32'h44);
        chk("post_rst_ovr",  32'(bus.overrun_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_serializer.md
# text_serializer

Downstream consumer of the text-RAM read stream. On each `read_enable` pulse it samples the 24-bit word returned by the text RAM, then sends it on a single serial line as three UART-style byte frames, most-significant byte first. A one-entry pending buffer absorbs a request that arrives during transmission. Requests beyond that are dropped and counted. It sits between the text RAM read port and the channel/transmit path of the communication system.

## Interface
- `CLKS_PER_BIT`, 2, clock cycles per serial bit; legal range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `read_enable`  in  1  one-cycle request pulse; the RAM read is issued in the same cycle.
- `read_address`  in  8  address accompanying `read_enable`.
- `ram_q`  in  24  text RAM read data, valid exactly one cycle after `read_enable`.
- `tx`  out  1  serial output; idle high.
- `busy`  out  1  high while a word is shifting or the pending slot is full.
- `word_done`  out  1  one-cycle pulse at the end of a word's last stop bit.
- `last_address`  out  8  address of the most recently completed word.
- `overrun_count`  out  8  saturating count of dropped requests.

## Operation
- **Fetch stage**
  - At an edge with `read_enable=1`, register `read_address` and set `fetch_v`.
  - At the next edge, the word is `ram_q`; deliver {address, word} and clear `fetch_v` unless a new pulse arrived.
  - Back-to-back pulses are accepted, one per cycle.
- **Delivery of a fetched word**
  - If the shifter is idle, or completing its last stop bit at this edge with pending empty, load the shifter.
  - Else, if pending is empty, or being drained into the shifter at this edge, write pending.
  - Else, drop the word and increment `overrun_count`; it saturates at 255.
- **Shifter FSM** states:
  - IDLE: `tx=1`, waits for a load.
  - START: `tx=0`.
  - DATA: 8 bits, LSB first.
  - PARITY: `TEXT_SERIALIZER_PARITY_EN` only.
  - STOP: `tx=1`.
- **Transitions**
  - A load moves IDLE to START.
  - Each state holds `CLKS_PER_BIT` cycles, with a bit counter in DATA. START → DATA → (PARITY) → STOP.
  - STOP with byte index 0 or 1: advance the index and go to START with the next byte.
  - STOP with byte index 2: pulse `word_done` and latch `last_address`. Then go to START with pending data, clearing pending, or to IDLE.
- **Byte order**: `[23:16]`, `[15:8]`, `[7:0]`.
- **Outputs**
  - `busy` = (state ≠ IDLE) | pending_valid.
  - All outputs are registered.

## Timing
- **Reset values**: `tx=1`, `busy=0`, `word_done=0`, `last_address=0`, `overrun_count=0`; pending, `fetch_v` and the FSM are cleared.
- **Reset mid-frame**: `tx` returns high immediately (asynchronous), and the in-flight word is discarded.
- **Latency**:
  - `read_enable` sampled at edge T; `tx` falls at edge T+1.
  - Frame length F = 10 bits without parity, 11 with parity.
  - One word takes 3·F·`CLKS_PER_BIT` cycles.
  - `word_done` is high for the single cycle following the word's final edge.
- **Chaining**: a pending word starts at the same edge the previous word ends. There are no idle cycles between words, and no idle cycles between bytes.
- **Throughput**: defaults give 60 cycles per word.

## Configuration
- `TEXT_SERIALIZER_PARITY_EN` defined:
  - Adds an even-parity bit after bit 7 of every byte; the bit is the XOR of the 8 data bits.
  - Frame is 11 bits; one word takes 66 cycles at the default `CLKS_PER_BIT`.
- Undefined: no PARITY state and 10-bit frames; the parity logic is absent.

## Test plan
- **Single word**: reset released, one pulse with address 0x05 and `ram_q=0x414243` one cycle later. Expected:
  - `tx` carries 0x41, then 0x42, then 0x43, each as start/LSB-first/stop with 2 cycles per bit.
  - `word_done` 60 cycles after the `tx` fall; `last_address=0x05`; `busy` low after that.
- **Back-to-back**: pulses at consecutive cycles with 0x000001 and 0x000002. Both words go out contiguously, with no idle `tx` cycles, two `word_done` pulses 60 cycles apart, and `overrun_count=0`.
- **Overrun**: three requests within one word time. Two are transmitted, `overrun_count=1`. Continue until 300 drops and check that `overrun_count` holds 255.
- **Simultaneous**: a pulse timed so its fetch lands on the last-stop-bit edge with pending full. Pending is transmitted next, the fetched word goes into pending, and nothing is dropped.
- **Reset mid-frame**: assert `reset` low during byte 1 DATA. Expected:
  - `tx=1` and `busy=0` immediately.
  - No `word_done`.
  - The next request is transmitted correctly.
- **Parity build**: `ram_q=0x070100` gives parity bits 1, 1, 0 per byte, `word_done` after 66 cycles.
